// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-channel sram-like request arbiter with in-order response routing
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (highest index wins).
module sram_like_arbiter #(
    parameter int CH_NUM   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CH_NUM-1:0]            s_req,
    input  logic [CH_NUM-1:0]            s_wr,
    input  logic [2*CH_NUM-1:0]          s_size,
    input  logic [DATA_W/8*CH_NUM-1:0]   s_wstrb,
    input  logic [ADDR_W*CH_NUM-1:0]     s_addr,
    input  logic [DATA_W*CH_NUM-1:0]     s_wdata,
    output logic [CH_NUM-1:0]            s_addr_ok,
    output logic [CH_NUM-1:0]            s_data_ok,
    output logic [DATA_W-1:0]            s_rdata,
    output logic                         m_req,
    output logic                         m_wr,
    output logic [1:0]                   m_size,
    output logic [DATA_W/8-1:0]          m_wstrb,
    output logic [ADDR_W-1:0]            m_addr,
    output logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_addr_ok,
    input  logic                         m_data_ok,
    input  logic [DATA_W-1:0]            m_rdata,
    output logic [$clog2(OT_DEPTH):0]    ot_count,
    output logic                         err_unexp_rsp
);

    localparam int ID_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PTR_W  = $clog2(OT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    logic             lock;
    logic [ID_W-1:0]  lock_id;
    logic [ID_W-1:0]  arb_id;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  id_mem [OT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    int               gsel;

`ifdef ARB_RR_EN
    logic [ID_W-1:0]  last_id;

    // Scan offsets from farthest to nearest so the channel right after last_id wins.
    always_comb begin
        arb_id = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (s_req[(int'(last_id) + 1 + i) % CH_NUM]) begin
                arb_id = ID_W'((int'(last_id) + 1 + i) % CH_NUM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_id <= '0;
        end else if (push) begin
            last_id <= grant_id;
        end
    end
`else
    always_comb begin
        arb_id = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (s_req[i]) begin
                arb_id = ID_W'(i);
            end
        end
    end
`endif

    // A locked channel that drops its request loses the lock; re-arbitrate so no idle channel is acked.
    always_comb begin
        if (lock && s_req[lock_id]) begin
            grant_id = lock_id;
        end else begin
            grant_id = arb_id;
        end
    end

    assign fifo_full  = (ot_count == CNT_W'(OT_DEPTH));
    assign fifo_empty = (ot_count == '0);
    assign m_req      = (|s_req) & ~fifo_full;
    assign push       = m_req & m_addr_ok;
    assign pop        = m_data_ok & ~fifo_empty;

    always_comb begin
        gsel    = int'(grant_id);
        m_wr    = s_wr[gsel];
        m_size  = s_size[gsel*2 +: 2];
        m_wstrb = s_wstrb[gsel*STRB_W +: STRB_W];
        m_addr  = s_addr[gsel*ADDR_W +: ADDR_W];
        m_wdata = s_wdata[gsel*DATA_W +: DATA_W];
    end

    always_comb begin
        s_addr_ok = '0;
        s_data_ok = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            s_addr_ok[k] = push & (grant_id == ID_W'(k));
            s_data_ok[k] = pop & (id_mem[rd_ptr] == ID_W'(k));
        end
    end

    assign s_rdata = m_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock          <= 1'b0;
            lock_id       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ot_count      <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            lock    <= m_req & ~m_addr_ok;
            lock_id <= grant_id;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                ot_count <= ot_count + 1'b1;
            end else if (pop && !push) begin
                ot_count <= ot_count - 1'b1;
            end
            if (m_data_ok && fifo_empty) begin
                err_unexp_rsp <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_id;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed self-checking bench for sram_like_arbiter (2 channels)
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_req;
    logic [1:0]  s_wr;
    logic [3:0]  s_size;
    logic [7:0]  s_wstrb;
    logic [63:0] s_addr;
    logic [63:0] s_wdata;
    logic [1:0]  s_addr_ok;
    logic [1:0]  s_data_ok;
    logic [31:0] s_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic [2:0]  ot_count;
    logic        err_unexp_rsp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_like_arbiter dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .ot_count(ot_count), .err_unexp_rsp(err_unexp_rsp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; s_req = '0; s_wr = '0; s_size = 4'b1010; s_wstrb = 8'hFF;
        s_addr = '0; s_wdata = '0; m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_addr_ok", s_addr_ok, 0);
        chk("rst_data_ok", s_data_ok, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_ot", ot_count, 0);
        chk("rst_err", err_unexp_rsp, 0);

        // single read on ch0
        tick();
        s_req = 2'b01; s_addr[31:0] = 32'h1C00_0000; m_addr_ok = 1;
        #1;
        chk("rd_m_req", m_req, 1);
        chk("rd_m_addr", m_addr, 32'h1C00_0000);
        chk("rd_addr_ok", s_addr_ok, 2'b01);
        tick();
        s_req = 0; m_addr_ok = 0;
        #1;
        chk("rd_ot1", ot_count, 1);
        chk("rd_addr_ok_low", s_addr_ok, 0);
        tick(); tick();
        m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_data_ok", s_data_ok, 2'b01);
        chk("rd_rdata", s_rdata, 32'hDEAD_BEEF);
        tick();
        m_data_ok = 0;
        #1;
        chk("rd_ot0", ot_count, 0);
        chk("rd_data_ok_low", s_data_ok, 0);

        // contention
        tick();
        s_addr = {32'h200, 32'h100}; s_req = 2'b11; m_addr_ok = 1;
`ifdef ARB_RR_EN
        #1; chk("rr_g0", s_addr_ok, 2'b10); tick();
        #1; chk("rr_g1", s_addr_ok, 2'b01); tick();
        #1; chk("rr_g2", s_addr_ok, 2'b10); tick();
        #1; chk("rr_g3", s_addr_ok, 2'b01); tick();
        s_req = 0; m_addr_ok = 0;
        #1; chk("rr_ot4", ot_count, 4);
        m_data_ok = 1;
        #1; chk("rr_d0", s_data_ok, 2'b10); tick();
        #1; chk("rr_d1", s_data_ok, 2'b01); tick();
        #1; chk("rr_d2", s_data_ok, 2'b10); tick();
        #1; chk("rr_d3", s_data_ok, 2'b01); tick();
`else
        #1;
        chk("fx_g_ch1", s_addr_ok, 2'b10);
        chk("fx_addr_ch1", m_addr, 32'h200);
        tick();
        s_req = 2'b01;
        #1;
        chk("fx_g_ch0", s_addr_ok, 2'b01);
        chk("fx_addr_ch0", m_addr, 32'h100);
        tick();
        s_req = 0; m_addr_ok = 0;
        #1; chk("fx_ot2", ot_count, 2);
        m_data_ok = 1;
        #1; chk("fx_d0", s_data_ok, 2'b10); tick();
        #1; chk("fx_d1", s_data_ok, 2'b01); tick();
`endif
        m_data_ok = 0;
        #1; chk("cont_ot0", ot_count, 0);

        // stall lock
        tick();
        s_addr = {32'h400, 32'h300}; s_req = 2'b01; m_addr_ok = 0;
        #1;
        chk("lk_c1_addr", m_addr, 32'h300);
        chk("lk_c1_ok", s_addr_ok, 0);
        tick();
        s_req = 2'b11;
        #1;
        chk("lk_c2_addr", m_addr, 32'h300);
        chk("lk_c2_ok", s_addr_ok, 0);
        tick();
        #1; chk("lk_c3_addr", m_addr, 32'h300);
        tick();
        m_addr_ok = 1;
        #1; chk("lk_ch0_acc", s_addr_ok, 2'b01);
        tick();
        s_req = 2'b10;
        #1;
        chk("lk_ch1_addr", m_addr, 32'h400);
        chk("lk_ch1_acc", s_addr_ok, 2'b10);
        tick();
        s_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1; chk("lk_d0", s_data_ok, 2'b01); tick();
        #1; chk("lk_d1", s_data_ok, 2'b10); tick();
        m_data_ok = 0;

        // fill the ID FIFO
        s_req = 2'b01; m_addr_ok = 1;
        tick(); tick(); tick(); tick();
        m_addr_ok = 0;
        #1;
        chk("full_ot4", ot_count, 4);
        chk("full_m_req", m_req, 0);
        m_addr_ok = 1;
        #1; chk("full_no_ack", s_addr_ok, 0);
        m_addr_ok = 0; m_data_ok = 1;
        #1; chk("full_pop_m_req", m_req, 0);
        tick();
        m_data_ok = 0;
        #1;
        chk("full_ot3", ot_count, 3);
        chk("full_m_req_back", m_req, 1);
        s_req = 0; m_data_ok = 1;
        tick(); tick(); tick();
        m_data_ok = 0;
        #1; chk("full_ot0", ot_count, 0);

        // in-order routing
        m_addr_ok = 1;
        s_req = 2'b10; tick();
        s_req = 2'b01; tick();
        s_req = 2'b10; tick();
        s_req = 0; m_addr_ok = 0;
        #1; chk("io_ot3", ot_count, 3);
        m_data_ok = 1; m_rdata = 32'h11;
        #1; chk("io_d0", s_data_ok, 2'b10); chk("io_r0", s_rdata, 32'h11); tick();
        m_rdata = 32'h22;
        #1; chk("io_d1", s_data_ok, 2'b01); chk("io_r1", s_rdata, 32'h22); tick();
        m_rdata = 32'h33;
        #1; chk("io_d2", s_data_ok, 2'b10); chk("io_r2", s_rdata, 32'h33); tick();
        m_data_ok = 0;
        #1; chk("io_ot0", ot_count, 0);

        // unexpected response, then reset with outstanding IDs
        m_data_ok = 1;
        #1; chk("err_no_data_ok", s_data_ok, 0);
        tick();
        m_data_ok = 0;
        #1;
        chk("err_set", err_unexp_rsp, 1);
        chk("err_ot0", ot_count, 0);
        s_req = 2'b01; m_addr_ok = 1;
        tick(); tick();
        s_req = 0; m_addr_ok = 0;
        #1; chk("rst2_ot2", ot_count, 2);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst2_ot0", ot_count, 0);
        chk("rst2_err", err_unexp_rsp, 0);
        chk("rst2_m_req", m_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- N-channel arbiter that merges per-channel sram-like requests (req/addr_ok/data_ok) onto one downstream sram-like port.
- Parametrised successor to the fixed inst/data sram split in the CPU top. Channel 0 is the IF stage and channel 1 is the EXE/MEM stage by default; more channels are available for cache/TLB walkers.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its issuing channel.

Parameters:
CH_NUM, 2, number of upstream channels (1..8); ID_W = max(1, clog2(CH_NUM)) is derived
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8
OT_DEPTH, 4, maximum outstanding transactions (power of 2, at least 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_req  in  CH_NUM  per-channel request valid
s_wr  in  CH_NUM  per-channel write flag
s_size  in  2*CH_NUM  per-channel size (0=byte, 1=half, 2=word)
s_wstrb  in  STRB_W*CH_NUM  per-channel byte strobes
s_addr  in  ADDR_W*CH_NUM  per-channel address
s_wdata  in  DATA_W*CH_NUM  per-channel write data
s_addr_ok  out  CH_NUM  per-channel request accepted
s_data_ok  out  CH_NUM  per-channel response valid
s_rdata  out  DATA_W  read data, broadcast to all channels
m_req  out  1  downstream request valid
m_wr  out  1  downstream write flag
m_size  out  2  downstream size
m_wstrb  out  STRB_W  downstream strobes
m_addr  out  ADDR_W  downstream address
m_wdata  out  DATA_W  downstream write data
m_addr_ok  in  1  downstream request accepted
m_data_ok  in  1  downstream response valid
m_rdata  in  DATA_W  downstream read data
ot_count  out  clog2(OT_DEPTH)+1  current outstanding count
err_unexp_rsp  out  1  sticky: m_data_ok arrived while no transaction was outstanding

Behaviour:
- The interface follows the codebase's existing convention: a single clock `clk` and a synchronous, active-high `reset`.
- Reset clears lock, grant, FIFO pointers, ot_count and err_unexp_rsp. After reset, all s_addr_ok, s_data_ok, m_req and ot_count are 0.
- Request path is combinational, with zero cycles of added latency. The m_* payload is a mux of the granted channel.
- m_req = |s_req & !fifo_full.
- Grant is computed combinationally when unlocked. Default policy is fixed priority, with the highest index winning (data over inst).
- Lock register: set when m_req && !m_addr_ok; cleared on m_addr_ok.
  - While locked, the grant is held on the locked channel and arbitration is ignored.
  - This keeps the m_* payload stable until accepted.
  - If the locked channel drops s_req (protocol violation), the lock clears the next cycle and arbitration restarts.
- s_addr_ok[k] = m_addr_ok & m_req & grant[k]. This is one-hot or zero.
- Handshake m_req & m_addr_ok pushes the granted channel ID into the ID FIFO (depth OT_DEPTH).
- FIFO full gates m_req to 0, even when a pop occurs in the same cycle. This avoids a comb path from m_data_ok to m_req.
- m_data_ok with the FIFO non-empty pops the FIFO head and sets s_data_ok[head] = 1; all other channels see 0. s_rdata = m_rdata.
- m_data_ok with the FIFO empty: no s_data_ok is raised and err_unexp_rsp is set until reset.
- Simultaneous push and pop with the FIFO neither full nor empty: both pointers advance and ot_count is unchanged.
- ot_count behaviour: +1 on push only, -1 on pop only, otherwise held.
- Pointer wrap: pointers are clog2(OT_DEPTH) bits with natural wrap. Full/empty are derived from ot_count.
- Responses are strictly in order. The downstream port is required to return in request order.
- Writes consume a FIFO slot and expect a data_ok, identical to reads.
- Reset mid-transaction drops all outstanding IDs. Any later m_data_ok then flags err_unexp_rsp, so the downstream must also be reset.

Optional Feature:
ARB_RR_EN.
- Defined: round-robin arbitration. A last-grant pointer updates on each m_addr_ok, and the channel after the last-granted one has top priority.
- Undefined: fixed priority with the highest index winning, and no pointer register.
- Lock behaviour is identical in both modes.

Test Plan:
- Single read: ch0 req addr=0x1C000000, m_addr_ok on the same cycle, m_data_ok 3 cycles later with rdata=0xDEADBEEF -> s_addr_ok=2'b01 for 1 cycle, s_data_ok=2'b01 with s_rdata=0xDEADBEEF, ot_count 0->1->0.
- Contention: ch0 and ch1 both req, m_addr_ok=1 -> fixed mode grants ch1 then ch0 in order; with ARB_RR_EN and 4 back-to-back cycles of both requesting, grants alternate 1,0,1,0.
- Stall lock: ch0 req with m_addr_ok=0 for 3 cycles, ch1 raises req in cycle 2 -> m_addr stays ch0's address, and the ch0 handshake completes before ch1 is granted.
- Full: OT_DEPTH=4, issue 4 requests with no data_ok -> ot_count=4, m_req=0 while reqs are pending; one m_data_ok -> m_req=1 the next cycle.
- In-order routing: issue ch1, ch0, ch1, then 3 data_ok carrying 0x11, 0x22, 0x33 -> s_data_ok order 2'b10, 2'b01, 2'b10 with matching rdata.
- Errors and reset: m_data_ok with the FIFO empty -> err_unexp_rsp=1 and no s_data_ok; reset with ot_count=2 -> ot_count=0 and err_unexp_rsp=0 the next cycle.
